// File: rtl/delay_line_ctrl.sv
// Multi-lane, valid-tagged delay line: runtime depth 0..MAX_DEPTH, stall, flush, guarded depth reload.
// Optional macro DELAY_LINE_ZERO_INVALID_EN zeroes data that is not carried by a valid beat.
module delay_line_ctrl #(
  parameter int DWIDTH    = 12,
  parameter int LANES     = 2,
  parameter int MAX_DEPTH = 8,
  parameter int DEF_DEPTH = 3,
  localparam int DW_D     = $clog2(MAX_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    flush_i,
  input  logic                    valid_i,
  input  logic [LANES*DWIDTH-1:0] data_i,
  input  logic                    depth_ld_i,
  input  logic [DW_D-1:0]         depth_i,
  output logic                    valid_o,
  output logic [LANES*DWIDTH-1:0] data_o,
  output logic                    busy_o,
  output logic [DW_D-1:0]         act_depth_o,
  output logic                    depth_err_o
);
  localparam int W = LANES * DWIDTH;
  localparam logic [DW_D-1:0] MAX_D = DW_D'(MAX_DEPTH);
  localparam logic [DW_D-1:0] DEF_D = DW_D'(DEF_DEPTH);
`ifdef DELAY_LINE_ZERO_INVALID_EN
  localparam bit ZERO_INV = 1'b1;
`else
  localparam bit ZERO_INV = 1'b0;
`endif

  if (MAX_DEPTH < 1 || DEF_DEPTH > MAX_DEPTH) begin : g_bad_cfg
    $fatal(1, "delay_line_ctrl: need MAX_DEPTH >= 1 and DEF_DEPTH <= MAX_DEPTH");
  end

  logic [MAX_DEPTH-1:0]        valid_q, valid_d;
  logic [MAX_DEPTH-1:0][W-1:0] data_q, data_d;
  logic [DW_D-1:0]             act_depth_q, act_depth_d;
  logic                        err_q, err_d;
  logic [MAX_DEPTH:0]          vchain;
  logic [MAX_DEPTH:0][W-1:0]   dchain;
  logic                        busy, ld_acc, ld_rej;

  // Only stages inside the active depth count; deeper stages shift but are invisible.
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < MAX_DEPTH; k++)
      if (DW_D'(k) < act_depth_q) busy = busy | valid_q[k];
  end

  assign ld_acc = depth_ld_i && (depth_i <= MAX_D) && (!busy || flush_i);
  assign ld_rej = depth_ld_i && !ld_acc;

  always_comb begin
    vchain      = {valid_q, valid_i};
    dchain      = {data_q, data_i};
    valid_d     = valid_q;
    data_d      = data_q;
    act_depth_d = act_depth_q;
    err_d       = ld_rej;
    if (ZERO_INV)
      for (int k = 0; k <= MAX_DEPTH; k++)
        if (!vchain[k]) dchain[k] = '0;
    if (en_i && !flush_i) begin
      valid_d = vchain[MAX_DEPTH-1:0];
      data_d  = dchain[MAX_DEPTH-1:0];
    end
    // Accepted reload also clears valids so beats parked beyond the old depth never surface.
    if (flush_i || ld_acc) valid_d = '0;
    if (ZERO_INV && (flush_i || ld_acc)) data_d = '0;
    if (ld_acc) act_depth_d = depth_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      data_q      <= '0;
      act_depth_q <= DEF_D;
      err_q       <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      act_depth_q <= act_depth_d;
      err_q       <= err_d;
    end
  end

  // Depth 0 is a combinational bypass; otherwise tap stage D-1.
  always_comb begin
    valid_o = valid_i;
    data_o  = data_i;
    if (act_depth_q != '0) begin
      valid_o = 1'b0;
      data_o  = '0;
      for (int k = 0; k < MAX_DEPTH; k++)
        if (act_depth_q == DW_D'(k + 1)) begin
          valid_o = valid_q[k];
          data_o  = data_q[k];
        end
    end
    if (ZERO_INV && !valid_o) data_o = '0;
  end

  assign busy_o      = busy;
  assign act_depth_o = act_depth_q;
  assign depth_err_o = err_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed vector bench for delay_line_ctrl (default parameters: DWIDTH=12, LANES=2, MAX=8, DEF=3).
module tb_delay_line_ctrl;
  localparam int DW = 12;
  localparam int LN = 2;
  localparam int MD = 8;
  localparam int DD = 3;
  localparam int DWD = $clog2(MD + 1);

  logic           clk = 1'b0;
  logic           rst, en_i, flush_i, valid_i, depth_ld_i;
  logic [LN*DW-1:0] data_i, data_o;
  logic [DWD-1:0] depth_i, act_depth_o;
  logic           valid_o, busy_o, depth_err_o;

  int n_chk = 0;
  int n_fail = 0;

  delay_line_ctrl #(.DWIDTH(DW), .LANES(LN), .MAX_DEPTH(MD), .DEF_DEPTH(DD)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .flush_i(flush_i), .valid_i(valid_i),
    .data_i(data_i), .depth_ld_i(depth_ld_i), .depth_i(depth_i),
    .valid_o(valid_o), .data_o(data_o), .busy_o(busy_o),
    .act_depth_o(act_depth_o), .depth_err_o(depth_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, fl, vi;
    logic [DW-1:0] di;
    logic ld;
    logic [DWD-1:0] dep;
    logic ev;
    logic [DW-1:0] ed;
    logic cd;
    logic eb;
    logic [DWD-1:0] ea;
    logic ee;
  } vec_t;

  vec_t vq[$];

  task automatic av(input logic en, fl, vi, input logic [DW-1:0] di, input logic ld,
                    input logic [DWD-1:0] dep, input logic ev, input logic [DW-1:0] ed,
                    input logic cd, eb, input logic [DWD-1:0] ea, input logic ee);
    vec_t v;
    v.en = en; v.fl = fl; v.vi = vi; v.di = di; v.ld = ld; v.dep = dep;
    v.ev = ev; v.ed = ed; v.cd = cd; v.eb = eb; v.ea = ea; v.ee = ee;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] zi_exp;

  initial begin
    rst = 1'b1; en_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; data_i = '0;
    depth_ld_i = 1'b0; depth_i = '0;
`ifdef DELAY_LINE_ZERO_INVALID_EN
    zi_exp = 12'h000;
`else
    zi_exp = 12'hABC;
`endif

    // en fl vi di     ld dep | ev ed  cd eb ea ee
    // stream 1..5 at D=3
    av(1,0,1,12'h001, 0,0,  0,12'h0,1, 0,3,0);
    av(1,0,1,12'h002, 0,0,  0,12'h0,1, 1,3,0);
    av(1,0,1,12'h003, 0,0,  0,12'h0,1, 1,3,0);
    av(1,0,1,12'h004, 0,0,  1,12'h001,1, 1,3,0);
    av(1,0,1,12'h005, 0,0,  1,12'h002,1, 1,3,0);
    av(1,0,0,12'h000, 0,0,  1,12'h003,1, 1,3,0);
    av(1,0,0,12'h000, 0,0,  1,12'h004,1, 1,3,0);
    av(1,0,0,12'h000, 0,0,  1,12'h005,1, 1,3,0);
    av(1,0,0,12'h000, 0,0,  0,12'h0,1, 0,3,0);
    // same stream with a 2-cycle stall after beat 2
    av(1,0,1,12'h001, 0,0,  0,12'h0,1, 0,3,0);
    av(1,0,1,12'h002, 0,0,  0,12'h0,1, 1,3,0);
    av(0,0,1,12'h003, 0,0,  0,12'h0,1, 1,3,0);
    av(0,0,1,12'h003, 0,0,  0,12'h0,1, 1,3,0);
    av(1,0,1,12'h003, 0,0,  0,12'h0,1, 1,3,0);
    av(1,0,1,12'h004, 0,0,  1,12'h001,1, 1,3,0);
    av(1,0,1,12'h005, 0,0,  1,12'h002,1, 1,3,0);
    av(1,0,0,12'h000, 0,0,  1,12'h003,1, 1,3,0);
    av(1,0,0,12'h000, 0,0,  1,12'h004,1, 1,3,0);
    av(1,0,0,12'h000, 0,0,  1,12'h005,1, 1,3,0);
    av(1,0,0,12'h000, 0,0,  0,12'h0,1, 0,3,0);
    // load depth 0 -> bypass, then depth 4 with a rejected load of 5
    av(1,0,0,12'h000, 1,0,  0,12'h0,1, 0,3,0);
    av(1,0,1,12'hABC, 0,0,  1,12'hABC,1, 0,0,0);
    av(1,0,0,12'h000, 1,4,  0,12'h0,1, 0,0,0);
    av(1,0,1,12'h007, 0,0,  0,12'h0,0, 0,4,0);
    av(1,0,0,12'h000, 1,5,  0,12'h0,0, 1,4,0);
    av(1,0,0,12'h000, 0,0,  0,12'h0,0, 1,4,1);
    av(1,0,0,12'h000, 0,0,  0,12'h0,0, 1,4,0);
    av(1,0,0,12'h000, 0,0,  1,12'h007,1, 1,4,0);
    av(1,0,0,12'h000, 0,0,  0,12'h0,1, 0,4,0);
    // D=3, two beats in flight, flush
    av(1,0,0,12'h000, 1,3,  0,12'h0,0, 0,4,0);
    av(1,0,1,12'h008, 0,0,  0,12'h0,0, 0,3,0);
    av(1,0,1,12'h009, 0,0,  0,12'h0,0, 1,3,0);
    av(1,1,1,12'h00A, 0,0,  0,12'h0,0, 1,3,0);
    av(1,0,0,12'h000, 0,0,  0,12'h0,0, 0,3,0);
    av(1,0,0,12'h000, 0,0,  0,12'h0,0, 0,3,0);
    av(1,0,0,12'h000, 0,0,  0,12'h0,0, 0,3,0);
    // flush + load while busy -> accepted
    av(1,0,1,12'h00B, 0,0,  0,12'h0,0, 0,3,0);
    av(1,1,0,12'h000, 1,6,  0,12'h0,0, 1,3,0);
    av(1,0,0,12'h000, 0,0,  0,12'h0,0, 0,6,0);
    av(1,0,0,12'h000, 0,0,  0,12'h0,0, 0,6,0);
    // out-of-range depth 9 while idle -> rejected
    av(1,0,0,12'h000, 1,9,  0,12'h0,0, 0,6,0);
    av(1,0,0,12'h000, 0,0,  0,12'h0,0, 0,6,1);
    av(1,0,0,12'h000, 0,0,  0,12'h0,0, 0,6,0);
    // D=2, invalid beat carrying 0xABC
    av(1,0,0,12'h000, 1,2,  0,12'h0,0, 0,6,0);
    av(1,0,0,12'hABC, 0,0,  0,12'h0,0, 0,2,0);
    av(1,0,0,12'h000, 0,0,  0,12'h0,0, 0,2,0);
    av(1,0,0,12'h000, 0,0,  0,zi_exp,1, 0,2,0);

    tick(); tick();
    rst = 1'b0;
    #4;
    chk("reset valid_o", 32'(valid_o), 32'd0);
    chk("reset data_o", 32'(data_o), 32'd0);
    chk("reset busy_o", 32'(busy_o), 32'd0);
    chk("reset act_depth_o", 32'(act_depth_o), 32'(DD));
    chk("reset depth_err_o", 32'(depth_err_o), 32'd0);
    tick();

    foreach (vq[i]) begin
      en_i = vq[i].en; flush_i = vq[i].fl; valid_i = vq[i].vi;
      data_i = {vq[i].di, vq[i].di};
      depth_ld_i = vq[i].ld; depth_i = vq[i].dep;
      #4;
      chk($sformatf("vec%0d valid_o", i), 32'(valid_o), 32'(vq[i].ev));
      if (vq[i].cd) chk($sformatf("vec%0d data_o", i), 32'(data_o), 32'({vq[i].ed, vq[i].ed}));
      chk($sformatf("vec%0d busy_o", i), 32'(busy_o), 32'(vq[i].eb));
      chk($sformatf("vec%0d act_depth_o", i), 32'(act_depth_o), 32'(vq[i].ea));
      chk($sformatf("vec%0d depth_err_o", i), 32'(depth_err_o), 32'(vq[i].ee));
      tick();
    end

    // Mid-stream reset at D=2: in-flight beat must vanish, depth returns to default
    en_i = 1'b1; flush_i = 1'b0; depth_ld_i = 1'b0; valid_i = 1'b1; data_i = {12'h005, 12'h005};
    tick();
    valid_i = 1'b0; data_i = '0; rst = 1'b1;
    #4;
    chk("pre-reset busy_o", 32'(busy_o), 32'd1);
    tick();
    rst = 1'b0;
    #4;
    chk("post-reset act_depth_o", 32'(act_depth_o), 32'(DD));
    chk("post-reset valid_o", 32'(valid_o), 32'd0);
    chk("post-reset data_o", 32'(data_o), 32'd0);
    chk("post-reset busy_o", 32'(busy_o), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      #4;
      chk($sformatf("post-reset drain%0d valid_o", c), 32'(valid_o), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/delay_line_ctrl.md
Name: delay_line_ctrl

Overview:
- Multi-lane, valid-tagged delay line for the poly-arith datapath.
- Depth is selectable at runtime up to MAX_DEPTH; supports stall (enable), flush and a safe depth-reload protocol.
- Sits between butterfly/multiplier pipelines to align coefficient lanes whose latency varies by operating mode.

Parameters:
- DWIDTH, 12, bit width of one coefficient lane
- LANES, 2, number of parallel coefficient lanes sharing one valid bit
- MAX_DEPTH, 8, number of physical stages; must be >= 1
- DEF_DEPTH, 3, active depth after reset; must be <= MAX_DEPTH
- DW_D, $clog2(MAX_DEPTH+1), width of depth field (derived; not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en_i  in  1  advance pipeline; 0 = stall, hold all stages
- flush_i  in  1  invalidate all in-flight beats
- valid_i  in  1  input beat valid
- data_i  in  LANES*DWIDTH  input lanes, lane k at [k*DWIDTH +: DWIDTH]
- depth_ld_i  in  1  request to load depth_i as the new active depth
- depth_i  in  DW_D  requested depth, 0..MAX_DEPTH
- valid_o  out  1  output beat valid
- data_o  out  LANES*DWIDTH  output lanes
- busy_o  out  1  any valid beat inside the active depth
- act_depth_o  out  DW_D  current active depth
- depth_err_o  out  1  one-cycle pulse on a rejected depth load

Behaviour:
- Storage: MAX_DEPTH stages, each holding {valid, LANES*DWIDTH data}.
- en_i=1: stage0 <= {valid_i, data_i}; stage k <= stage k-1.
- en_i=0: all stages hold and valid_i is ignored. An input beat is accepted only when en_i=1.
- Output, act_depth = D:
  - D=0: combinational bypass; valid_o=valid_i, data_o=data_i.
  - D>0: {valid_o, data_o} = stage[D-1], registered output.
- Consumer handshake: a beat is taken when valid_o=1 and en_i=1.
- Latency: exactly D enabled cycles; stalled cycles add 1:1.
- busy_o: combinational OR of valid bits of stages 0..D-1; 0 when D=0. Stages >= D still shift but are ignored.
- flush_i=1: next cycle all stage valid bits = 0; data bits unchanged. Flush overrides en_i, and the input beat in that cycle is dropped.
- Depth load (depth_ld_i=1):
  - Accepted when depth_i <= MAX_DEPTH and (busy_o=0 or flush_i=1). Next cycle: act_depth <= depth_i and all stage valid bits cleared, so stale beats in stages beyond the old depth never appear.
  - Rejected when busy_o=1 with no flush, or when depth_i > MAX_DEPTH. act_depth unchanged; depth_err_o=1 on the next cycle for one cycle.
  - Load in the same cycle as en_i=1 and valid_i=1 while accepted: the input beat is dropped (valid cleared).
- Reset values: all stage valids 0, stage data 0, act_depth_o=DEF_DEPTH, depth_err_o=0.
  - Therefore valid_o=0 and data_o=0 (unless DEF_DEPTH=0, which bypasses) and busy_o=0.
  - Reset mid-stream discards all beats; rst has priority over flush, load and en.
- Elaboration-time check: fatal if MAX_DEPTH < 1 or DEF_DEPTH > MAX_DEPTH.

Optional Feature:
- Macro: DELAY_LINE_ZERO_INVALID_EN.
- Defined:
  - Stage data is written as 0 whenever the incoming valid is 0.
  - Flush also zeroes stage data.
  - data_o is forced to 0 whenever valid_o=0, including in bypass.
  - Purpose: no stale coefficients on the bus; lowers toggle power.
- Undefined: data travels unmodified regardless of valid; flush clears valid bits only.

Test Plan:
- Reset with DEF_DEPTH=3, LANES=2, en_i=1, inputs 0x001..0x005 on consecutive cycles -> valid_o high for 5 cycles starting 3 cycles after the first beat; data_o = 0x001..0x005 in order on both lanes.
- Same stream with en_i=0 for 2 cycles after the 2nd beat -> outputs freeze, no beat lost or duplicated; 3rd beat appears 5 cycles after its launch.
- Idle, load depth_i=0 -> act_depth_o=0 next cycle and data_o tracks data_i 0xABC in the same cycle. Then, with 1 beat in flight at depth 4, load 5 -> depth_err_o pulses once and act_depth_o stays 4.
- 2 beats in flight at D=3, pulse flush_i -> busy_o=0 next cycle, valid_o never asserts for them. flush_i+depth_ld_i with depth_i=6 in the same cycle -> accepted, act_depth_o=6.
- depth_ld_i with depth_i=9, MAX_DEPTH=8, idle -> rejected, depth_err_o=1 for one cycle, act_depth_o unchanged.
- With DELAY_LINE_ZERO_INVALID_EN: valid_i=0 and data 0xABC at D=2 -> data_o=0 two cycles later. Without the macro -> data_o=0xABC with valid_o=0.
